// File: rtl/ohc_modulo_adder_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ohc_modulo_adder_pipe
//  Description : Two-stage pipelined residue-to-one-hot converter with an
//                optional modulo-MOD addition done as a one-hot rotation.
//                Valid/ready handshake on both input and output sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module ohc_modulo_adder_pipe #(
    parameter  int MOD = 9,
    localparam int W   = $clog2(MOD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MOD-1:0] out_ohc,
    output logic [W-1:0]   out_bin,
    output logic           out_err
);

    // The modulus is widened by one bit so range checks never lose the top
    // value (it can equal 2**W when it is a power of two).
    localparam logic [W:0] c_MOD_EXT = (W+1)'(MOD);

    // ------------------------------------------------------------------------
    // Handshake: a stage may load when it is empty or its successor advances.
    // in_ready depends only on pipeline state and out_ready.
    // ------------------------------------------------------------------------
    logic s1_adv;
    logic s2_adv;

    // ------------------------------------------------------------------------
    // Stage 1 state
    // ------------------------------------------------------------------------
    logic           s1_valid_q;
    logic [MOD-1:0] ohc_a_q;
    logic [MOD-1:0] ohc_a_d;
    logic [W-1:0]   b_q;
    logic           mode_q;
    logic           err_q;
    logic           err_d;

    // ------------------------------------------------------------------------
    // Stage 2 state (drives the outputs directly)
    // ------------------------------------------------------------------------
    logic           s2_valid_q;
    logic [MOD-1:0] ohc_q;
    logic [MOD-1:0] ohc_d;
    logic [W-1:0]   bin_q;
    logic [W-1:0]   bin_d;
    logic           out_err_q;

    // Advance conditions for each stage.
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = ~s1_valid_q | s2_adv;
        in_ready = s1_adv;
    end

    // Range check of the operands and one-hot decode of a; b is only
    // considered in add mode, and an error forces the code to all-zero.
    always_comb begin
        err_d   = ({1'b0, in_a} >= c_MOD_EXT)
                | (in_mode & ({1'b0, in_b} >= c_MOD_EXT));
        ohc_a_d = '0;
        for (int k = 0; k < MOD; k++) begin
            ohc_a_d[k] = ~err_d & (in_a == W'(k));
        end
    end

    // Stage 1 registers: load a new transfer whenever stage 1 advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            ohc_a_q    <= '0;
            b_q        <= '0;
            mode_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                ohc_a_q <= ohc_a_d;
                b_q     <= in_b;
                mode_q  <= in_mode;
                err_q   <= err_d;
            end
        end
    end

    // Rotate the one-hot code left by b within MOD bits (the modulo add),
    // then encode the single set bit back to binary. Rotation is done on a
    // doubled copy so the wrap-around never needs a W+1-bit sum. A zero
    // code (error) rotates and encodes to zero.
    always_comb begin
        if (mode_q) begin
            ohc_d = MOD'(({ohc_a_q, ohc_a_q} << b_q) >> MOD);
        end else begin
            ohc_d = ohc_a_q;
        end
        bin_d = '0;
        for (int k = 0; k < MOD; k++) begin
            if (ohc_d[k]) begin
                bin_d = bin_d | W'(k);
            end
        end
    end

    // Stage 2 registers: hold while stalled, keep last data when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            ohc_q      <= '0;
            bin_q      <= '0;
            out_err_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                ohc_q     <= ohc_d;
                bin_q     <= bin_d;
                out_err_q <= err_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_ohc   = ohc_q;
    assign out_bin   = bin_q;
    assign out_err   = out_err_q;

endmodule
`default_nettype wire
